uart_bus_bridge: RTL and testbench

Serial-to-bus initiator that lets a host on the UART drive the SoC's peripheral bus for boot loading and debug. It consumes received bytes from the UART receive path, decodes framed read and write commands, and issues single-cycle transactions on the same simple bus the UART controller responds on. It returns an acknowledge byte or read data through the UART transmit path. It sits between the UART byte streams and the bus, as a bus master alongside the core.

---
 rtl/uart_bridge_pkg.sv | 18 +
 rtl/uart_bus_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and framing constants for the UART-to-bus bridge.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS,
    ST_RESP,
    ST_NAK
  } bridge_state_e;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

endpackage

// File: rtl/uart_bus_bridge.sv
// UART byte stream to single-cycle bus initiator: decodes framed read/write
// commands, strobes the bus, and returns ACK, NAK or little-endian read data.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a command byte
// ST_ADDR  | collecting NB little-endian address bytes
// ST_WDATA | collecting NB little-endian write-data bytes
// ST_BUS   | one-cycle read or write strobe
// ST_RESP  | offering ACK or the NB read-data bytes
// ST_NAK   | offering a single NAK after a bad command
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int BusDataWidth  = 32,
  parameter int TimeoutCycles = 500_000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_valid_i,
  input  logic [7:0]              rx_data_i,
  output logic                    tx_valid_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ready_i,
  output logic                    bus_wr_en_o,
  output logic                    bus_rd_en_o,
  output logic [BusDataWidth-1:0] bus_addr_o,
  output logic [BusDataWidth-1:0] bus_wdata_o,
  input  logic [BusDataWidth-1:0] bus_rdata_i,
  output logic                    err_o
);

  localparam int NB = BusDataWidth / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TimeoutCycles);

  bridge_state_e state_q, state_d;

  logic [CW-1:0]           cnt_q;
  logic [TW-1:0]           tmr_q;
  logic [BusDataWidth-1:0] addr_q;
  logic [BusDataWidth-1:0] wdata_q;
  logic [BusDataWidth-1:0] resp_q;
  logic                    is_wr_q;
  logic                    err_q;

  logic good_cmd;
  logic collecting;
  logic last_byte;
  logic timed_out;
  logic busy;
  logic hs;
  logic err_d;

  assign good_cmd   = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);
  assign collecting = (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign last_byte  = rx_valid_i && (cnt_q == LAST_BYTE);
  // A byte arriving on the terminal-count cycle still counts as in time.
  assign timed_out  = collecting && !rx_valid_i && (tmr_q == '0);
  assign busy       = (state_q == ST_BUS) || (state_q == ST_RESP) || (state_q == ST_NAK);
  assign hs         = tx_valid_o && tx_ready_i;
  assign err_d      = (state_q == ST_IDLE && rx_valid_i && !good_cmd)
                    || timed_out
                    || (busy && rx_valid_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) state_d = good_cmd ? ST_ADDR : ST_NAK;
      end
      ST_ADDR: begin
        if (last_byte)      state_d = is_wr_q ? ST_WDATA : ST_BUS;
        else if (timed_out) state_d = ST_IDLE;
      end
      ST_WDATA: begin
        if (last_byte)      state_d = ST_BUS;
        else if (timed_out) state_d = ST_IDLE;
      end
      ST_BUS:  state_d = ST_RESP;
      ST_RESP: begin
        if (hs && (is_wr_q || cnt_q == LAST_BYTE)) state_d = ST_IDLE;
      end
      ST_NAK: begin
        if (hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_wr_en_o = 1'b0;
    bus_rd_en_o = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    case (state_q)
      ST_BUS: begin
        bus_wr_en_o = is_wr_q;
        bus_rd_en_o = !is_wr_q;
      end
      ST_RESP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = is_wr_q ? ACK : resp_q[7:0];
      end
      ST_NAK: begin
        tx_valid_o = 1'b1;
        tx_data_o  = NAK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      tmr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;

      if (state_d != state_q)
        cnt_q <= '0;
      else if ((collecting && rx_valid_i) || (state_q == ST_RESP && hs))
        cnt_q <= cnt_q + CW'(1);

      // Inter-byte down-counter, reloaded by every byte of the frame.
      if (state_d == ST_ADDR || state_d == ST_WDATA)
        tmr_q <= rx_valid_i ? TMR_LOAD : tmr_q - TW'(1);
      else
        tmr_q <= '0;

      if (state_q == ST_IDLE && rx_valid_i && good_cmd)
        is_wr_q <= (rx_data_i == CMD_WR);

      if (state_q == ST_ADDR && rx_valid_i)
        addr_q[8*cnt_q +: 8] <= rx_data_i;

      if (state_q == ST_WDATA && rx_valid_i)
        wdata_q[8*cnt_q +: 8] <= rx_data_i;

      if (state_q == ST_BUS)
        resp_q <= bus_rdata_i;
      else if (state_q == ST_RESP && hs)
        resp_q <= resp_q >> 8;
    end
  end

  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: a memory model predicts bus traffic and
// response bytes; a negedge monitor pops and compares whatever the DUT emits.
module tb_uart_bus_bridge;
  import uart_bridge_pkg::*;

  localparam int W  = 32;
  localparam int NB = W / 8;
  localparam int TO = 100;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         rx_valid_i = 1'b0;
  logic [7:0]   rx_data_i = 8'h00;
  logic         tx_valid_o;
  logic [7:0]   tx_data_o;
  logic         tx_ready_i;
  logic         bus_wr_en_o;
  logic         bus_rd_en_o;
  logic [W-1:0] bus_addr_o;
  logic [W-1:0] bus_wdata_o;
  logic [W-1:0] bus_rdata_i = '0;
  logic         err_o;

  uart_bus_bridge #(.BusDataWidth(W), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .bus_wr_en_o(bus_wr_en_o), .bus_rd_en_o(bus_rd_en_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         wr;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } bus_txn_t;

  bus_txn_t     bus_q[$];
  logic [7:0]   tx_q[$];
  logic [W-1:0] mem [logic [W-1:0]];

  int vectors = 0;
  int miscompares = 0;
  int err_exp = 0;
  int err_seen = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready modes: 0 always ready, 1 held off 20 cycles per byte, 2 random.
  initial begin
    int wc;
    wc = 0;
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0: tx_ready_i = 1'b1;
        1: begin
          if (!tx_valid_o) begin
            tx_ready_i = 1'b0;
            wc = 0;
          end else if (wc < 20) begin
            tx_ready_i = 1'b0;
            wc++;
          end else begin
            tx_ready_i = 1'b1;
            wc = 0;
          end
        end
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit         hold_pend;
    logic [7:0] hold_data;
    bus_txn_t   t;
    logic [7:0] b;
    hold_pend = 1'b0;
    hold_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hold_pend = 1'b0;
      end else begin
        if (err_o) err_seen++;
        if (hold_pend) begin
          check("tx_hold_valid", W'(tx_valid_o), W'(1));
          check("tx_hold_data", W'(tx_data_o), W'(hold_data));
        end
        hold_pend = tx_valid_o && !tx_ready_i;
        hold_data = tx_data_o;
        if (bus_wr_en_o || bus_rd_en_o) begin
          if (bus_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: got addr %h expected no strobe", bus_addr_o);
          end else begin
            t = bus_q.pop_front();
            check("bus_kind", W'({bus_wr_en_o, bus_rd_en_o}), t.wr ? W'(2) : W'(1));
            check("bus_addr", bus_addr_o, t.addr);
            if (t.wr) check("bus_wdata", bus_wdata_o, t.data);
          end
        end
        if (tx_valid_o && tx_ready_i) begin
          if (tx_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tx: got %h expected no byte", tx_data_o);
          end else begin
            b = tx_q.pop_front();
            check("tx_byte", W'(tx_data_o), W'(b));
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] v);
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b1;
    rx_data_i  = v;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(posedge clk_i);
  endtask

  task automatic send_word(input logic [W-1:0] v);
    for (int i = 0; i < NB; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d);
    bus_txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d;
    bus_q.push_back(t);
    tx_q.push_back(ACK);
    mem[a] = d;
    send_byte(CMD_WR);
    send_word(a);
    send_word(d);
  endtask

  task automatic do_read(input logic [W-1:0] a);
    bus_txn_t     t;
    logic [W-1:0] d;
    if (!mem.exists(a)) mem[a] = W'($urandom);
    d = mem[a];
    bus_rdata_i = d;
    t.wr = 1'b0; t.addr = a; t.data = '0;
    bus_q.push_back(t);
    for (int i = 0; i < NB; i++) tx_q.push_back(d[8*i +: 8]);
    send_byte(CMD_RD);
    send_word(a);
  endtask

  task automatic bad_cmd(input logic [7:0] c);
    tx_q.push_back(NAK);
    err_exp++;
    send_byte(c);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_pending", W'(tx_q.size() + bus_q.size()), W'(0));
    tx_q.delete();
    bus_q.delete();
    repeat (3) @(negedge clk_i);
    check("err_count", W'(err_seen), W'(err_exp));
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_valid", W'(tx_valid_o), W'(0));
    check("rst_tx_data", W'(tx_data_o), W'(0));
    check("rst_wr_en", W'(bus_wr_en_o), W'(0));
    check("rst_rd_en", W'(bus_rd_en_o), W'(0));
    check("rst_addr", bus_addr_o, W'(0));
    check("rst_wdata", bus_wdata_o, W'(0));
    check("rst_err", W'(err_o), W'(0));
  endtask

  initial begin
    logic [7:0]   c;
    logic [W-1:0] a;
    int           r;

    #12;
    check_reset_outputs();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    ready_mode = 0;
    do_write(32'hDEADBEEF, 32'h12345678);
    wait_done();

    mem[32'h0000_1000] = 32'hCAFEF00D;
    do_read(32'h0000_1000);
    wait_done();

    bad_cmd(8'h41);
    wait_done();

    // Frame abandoned after two address bytes must time out silently.
    send_byte(CMD_WR);
    send_byte(8'h11);
    send_byte(8'h22);
    err_exp++;
    repeat (3 * TO) @(posedge clk_i);
    wait_done();
    do_read(32'h0000_1000);
    wait_done();

    ready_mode = 1;
    do_read(32'h0000_2004);
    wait_done();

    do_read(32'hDEADBEEF);
    repeat (5) @(posedge clk_i);
    err_exp++;
    send_byte(8'hAA);
    wait_done();
    ready_mode = 0;

    // Reset in the middle of the write-data phase.
    send_byte(CMD_WR);
    send_word(32'hA5A5_0000);
    send_byte(8'h01);
    send_byte(8'h02);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    check("post_reset_addr", bus_addr_o, W'(0));
    wait_done();

    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? W'({$urandom_range(0, 7), 2'b00}) : W'($urandom);
      if (r < 4) begin
        do_write(a, W'($urandom));
      end else if (r < 8) begin
        do_read(a);
      end else begin
        c = 8'($urandom);
        if (c == CMD_WR || c == CMD_RD) c = 8'h41;
        bad_cmd(c);
      end
      wait_done();
    end
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    miscompares++;
    $display("FAIL watchdog: got still running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
